// File: rtl/prbs9_checker.sv
// Self-synchronising receive checker for the x^9 + x^5 + 1 PRBS9 stream.
// Acquires lock from the incoming bits, then counts bits and errors against a free-running reference.
module prbs9_checker #(
  parameter int unsigned LOCK_THR = 32,
  parameter int unsigned LOSS_WIN = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             s_rst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_t;

  localparam logic [7:0]       LOCK_THR_L = 8'(LOCK_THR);
  localparam logic [15:0]      LOSS_WIN_L = 16'(LOSS_WIN);
  localparam logic [15:0]      LOSS_THR_L = 16'(LOSS_THR);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t      state;
  logic [8:0]  hist;
  logic [3:0]  fill_cnt;
  logic [7:0]  match_cnt;
  logic [15:0] win_cnt;
  logic [15:0] win_err;

  logic        exp_bit;
  logic        mismatch;
  logic [7:0]  match_nxt;
  logic [15:0] win_cnt_nxt;
  logic [15:0] win_err_nxt;

  // Prediction follows b[n] = b[n-9] ^ b[n-5]; window sums include the bit being accepted.
  assign exp_bit     = hist[8] ^ hist[4];
  assign mismatch    = data_i ^ exp_bit;
  assign match_nxt   = match_cnt + 8'd1;
  assign win_cnt_nxt = win_cnt + 16'd1;
  assign win_err_nxt = win_err + {15'd0, mismatch};

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state     <= FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      bit_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;
      if (data_val_i) begin
        case (state)
          FILL: begin
            hist <= {hist[7:0], data_i};
            if (fill_cnt == 4'd8) begin
              state     <= SYNC;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 4'd1;
            end
          end
          SYNC: begin
            hist <= {hist[7:0], data_i};
            // An all-zero history would predict zeros forever, so it never earns credit.
            if (hist != 9'd0) begin
              if (!mismatch) begin
                if (match_nxt == LOCK_THR_L) begin
                  state     <= LOCKED;
                  locked_o  <= 1'b1;
                  match_cnt <= '0;
                  win_cnt   <= '0;
                  win_err   <= '0;
                end else begin
                  match_cnt <= match_nxt;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            hist  <= {hist[7:0], exp_bit};
            err_o <= mismatch;
            if (win_err_nxt >= LOSS_THR_L) begin
              state     <= FILL;
              locked_o  <= 1'b0;
              hist      <= '0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else if (win_cnt_nxt == LOSS_WIN_L) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt_nxt;
              win_err <= win_err_nxt;
            end
          end
          default: begin
            state    <= FILL;
            locked_o <= 1'b0;
          end
        endcase
      end

      // A clear wins over the increment of the same cycle.
      if (clr_i) begin
        bit_cnt_o <= '0;
        err_cnt_o <= '0;
      end else if (data_val_i && state == LOCKED) begin
        if (bit_cnt_o != CNT_MAX) begin
          bit_cnt_o <= bit_cnt_o + CNT_ONE;
        end
        if (mismatch && err_cnt_o != CNT_MAX) begin
          err_cnt_o <= err_cnt_o + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: a PRBS9 source, a behavioural expectation model and a scoreboard queue.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_prbs9_checker;

  logic        clk;
  logic        s_rst;
  logic        data;
  logic        data_val;
  logic        clr;
  logic        locked;
  logic        err;
  logic [31:0] bit_cnt;
  logic [31:0] err_cnt;
  logic        locked_s;
  logic        err_s;
  logic [3:0]  bit_cnt_s;
  logic [3:0]  err_cnt_s;

  typedef struct {
    logic        chk;
    logic        lk;
    logic        er;
    logic [31:0] bc;
    logic [31:0] ec;
    logic [3:0]  bc4;
    logic [3:0]  ec4;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [8:0]  gen;
  bit          m_lk;
  int          m_acq;
  int          m_wpos;
  int          m_werr;
  logic [31:0] m_bc;
  logic [31:0] m_ec;
  logic [3:0]  m_bc4;
  logic [3:0]  m_ec4;

  prbs9_checker dut (
    .clk_i      (clk),
    .s_rst_i    (s_rst),
    .data_i     (data),
    .data_val_i (data_val),
    .clr_i      (clr),
    .locked_o   (locked),
    .err_o      (err),
    .bit_cnt_o  (bit_cnt),
    .err_cnt_o  (err_cnt)
  );

  prbs9_checker #(.CNT_W(4)) dut_sat (
    .clk_i      (clk),
    .s_rst_i    (s_rst),
    .data_i     (data),
    .data_val_i (data_val),
    .clr_i      (clr),
    .locked_o   (locked_s),
    .err_o      (err_s),
    .bit_cnt_o  (bit_cnt_s),
    .err_cnt_o  (err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one cycle of stimulus and pushes the outcome the checker must show after the edge.
  task automatic applyStimulus(input bit rst, input bit val, input bit flip, input bit clr_in,
                               input bit zero, input bit chk);
    exp_t e;
    bit   gb;
    s_rst    = rst;
    data_val = val;
    clr      = clr_in;
    if (val && !zero) begin
      gb   = gen[8] ^ gen[4];
      gen  = {gen[7:0], gb};
      data = gb ^ flip;
    end else if (val) begin
      data = 1'b0;
    end else begin
      data = 1'($urandom_range(0, 1));
    end

    e.er = 1'b0;
    if (rst) begin
      m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0;
      m_bc = '0; m_ec = '0; m_bc4 = '0; m_ec4 = '0;
    end else if (chk) begin
      if (val && m_lk) begin
        m_bc  = m_bc + 1;
        m_bc4 = (m_bc4 == 4'hF) ? 4'hF : m_bc4 + 4'd1;
        m_wpos++;
        if (flip) begin
          e.er  = 1'b1;
          m_ec  = m_ec + 1;
          m_ec4 = (m_ec4 == 4'hF) ? 4'hF : m_ec4 + 4'd1;
          m_werr++;
        end
        if (m_werr == 8) begin
          m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0;
        end else if (m_wpos == 64) begin
          m_wpos = 0; m_werr = 0;
        end
      end else if (val && !zero) begin
        m_acq++;
        if (m_acq == 41) begin
          m_lk = 1; m_wpos = 0; m_werr = 0;
        end
      end
      if (clr_in) begin
        m_bc = '0; m_ec = '0; m_bc4 = '0; m_ec4 = '0;
      end
    end
    e.chk = chk;
    e.lk  = m_lk;
    e.bc  = m_bc;
    e.ec  = m_ec;
    e.bc4 = m_bc4;
    e.ec4 = m_ec4;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    e = sb.pop_front();
    doCheck("err_o", {31'd0, err}, {31'd0, e.er});
    doCheck("err_o_sat", {31'd0, err_s}, {31'd0, e.er});
    if (e.chk) begin
      doCheck("locked_o", {31'd0, locked}, {31'd0, e.lk});
      doCheck("locked_o_sat", {31'd0, locked_s}, {31'd0, e.lk});
      doCheck("bit_cnt_o", bit_cnt, e.bc);
      doCheck("err_cnt_o", err_cnt, e.ec);
      doCheck("bit_cnt_o_sat", {28'd0, bit_cnt_s}, {28'd0, e.bc4});
      doCheck("err_cnt_o_sat", {28'd0, err_cnt_s}, {28'd0, e.ec4});
    end
  endtask

  task automatic step(input bit rst, input bit val, input bit flip, input bit clr_in,
                      input bit zero, input bit chk);
    applyStimulus(rst, val, flip, clr_in, zero, chk);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    gen      = 9'h1FF;
    s_rst    = 1'b0;
    data     = 1'b0;
    data_val = 1'b0;
    clr      = 1'b0;
    m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0;
    m_bc = '0; m_ec = '0; m_bc4 = '0; m_ec4 = '0;

    $display("[TB] clean lock");
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 41; i++) step(0, 1, 0, 0, 0, 1);
    doCheck("lock_at_41", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 1000; i++) step(0, 1, 0, 0, 0, 1);
    doCheck("clean_bit_cnt", bit_cnt, 32'd1000);
    doCheck("clean_err_cnt", err_cnt, 32'd0);

    $display("[TB] single error");
    for (int i = 0; i < 21; i++) step(0, 1, (i == 10), 0, 0, 1);
    doCheck("single_err_cnt", err_cnt, 32'd1);
    doCheck("single_locked", {31'd0, locked}, 32'd1);

    $display("[TB] loss of lock");
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 41; i++) step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 1, (i % 2 == 0), 0, 0, 1);
    doCheck("loss_locked", {31'd0, locked}, 32'd0);
    doCheck("loss_err_cnt", err_cnt, 32'd8);
    for (int i = 0; i < 41; i++) step(0, 1, 0, 0, 0, 1);
    doCheck("relock_locked", {31'd0, locked}, 32'd1);
    doCheck("relock_err_cnt", err_cnt, 32'd8);

    $display("[TB] gapped valid");
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 500; i++) step(0, ($urandom_range(0, 99) < 30), 0, 0, 0, 1);
    doCheck("gapped_locked", {31'd0, locked}, 32'd1);
    doCheck("gapped_bit_cnt", bit_cnt, m_bc);

    $display("[TB] all-zero input");
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 1000; i++) step(0, 1, 0, 0, 1, 1);
    doCheck("zero_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0, 0);
    doCheck("zero_then_gen_locked", {31'd0, locked}, 32'd1);
    doCheck("zero_then_gen_err_cnt", err_cnt, 32'd0);

    $display("[TB] clear and saturation");
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 61; i++) step(0, 1, 0, 0, 0, 1);
    doCheck("sat_bit_cnt4", {28'd0, bit_cnt_s}, 32'd15);
    doCheck("sat_bit_cnt32", bit_cnt, 32'd20);
    step(0, 1, 0, 1, 0, 1);
    doCheck("clr_bit_cnt", bit_cnt, 32'd0);
    step(0, 1, 0, 0, 0, 1);
    doCheck("resume_bit_cnt", bit_cnt, 32'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    doCheck("rst_locked", {31'd0, locked}, 32'd0);
    doCheck("rst_bit_cnt", bit_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs9_checker.md
# prbs9_checker

Receive-side checker for the x^9 + x^5 + 1 PRBS9 stream produced by the 9-bit LFSR generator. It sits directly downstream of the generator, or at the far end of the link under test. It consumes one bit per qualified cycle and self-synchronises to the sequence with no seed exchange. Once locked, it counts received bits and bit errors for the test/status registers.

## Interface
- LOCK_THR, 32: consecutive correct predictions in SYNC required to declare lock (1..255).
- LOSS_WIN, 64: length, in locked valid bits, of one loss-detection window (2..65535).
- LOSS_THR, 8: errors inside one window that force loss of lock (1..LOSS_WIN).
- CNT_W, 32: width of the bit and error counters.
- clk_i  in  1  system clock, all logic on rising edge.
- s_rst_i  in  1  synchronous, active-high reset.
- data_i  in  1  received PRBS bit.
- data_val_i  in  1  data_i is valid this cycle (mirrors generator ack_i).
- clr_i  in  1  synchronous clear of bit_cnt_o and err_cnt_o only.
- locked_o  out  1  checker is in LOCKED.
- err_o  out  1  one-cycle pulse: the bit accepted on the previous cycle mismatched while locked.
- bit_cnt_o  out  CNT_W  bits checked while locked, saturating.
- err_cnt_o  out  CNT_W  errors detected while locked, saturating.

## Operation
- hist[8:0] is the history register. hist[0] holds the newest bit and hist[8] the bit accepted 9 valid cycles earlier. Prediction: exp = hist[8] ^ hist[4]. This matches the generator recurrence b[n] = b[n-9] ^ b[n-5].
- Only cycles with data_val_i=1 advance anything. Cycles with data_val_i=0 hold all state, and err_o=0 on the following cycle.
- **FILL**
  - Shift data_i into hist.
  - After the 9th accepted bit, go to SYNC with match_cnt=0.
- **SYNC**
  - Shift data_i into hist. This is the self-synchronising mode.
  - If hist==0, the all-zero lock-up pattern: do not count and hold match_cnt. This prevents locking onto a constant-zero line.
  - Else if data_i==exp, increment match_cnt. When it reaches LOCK_THR, go to LOCKED with window counters cleared.
  - Else set match_cnt=0.
- **LOCKED**
  - Shift exp, not data_i, into hist. The reference is free-running, so a single flipped bit counts as exactly one error.
  - Every accepted bit increments bit_cnt and win_cnt.
  - If data_i!=exp, increment err_cnt and win_err, and pulse err_o.
- **Loss window**
  - When win_err including the current bit reaches LOSS_THR, go to FILL on the next edge. Clear hist, match_cnt and the window counters. Retain bit_cnt and err_cnt.
  - Otherwise, when win_cnt reaches LOSS_WIN, clear win_cnt and win_err.
- **Counters**
  - bit_cnt and err_cnt saturate at 2^CNT_W-1.
  - clr_i has priority over a same-cycle increment: the result is 0 and that cycle's increment is lost.
  - clr_i does not affect the state machine.
- **Reset**
  - Reset leaves state=FILL, hist=0, all counters 0, locked_o=0, err_o=0.
  - Reset mid-operation is equivalent to power-up: lock is dropped immediately.

## Timing
- All outputs are registered.
- err_o, bit_cnt_o and err_cnt_o update on the edge that samples the data_val_i cycle. They are visible one cycle after that valid bit.
- locked_o rises on the edge sampling the LOCK_THR-th consecutive match. With continuous valid input and no errors, that is bit number 9+LOCK_THR, counted from the first valid bit after reset.
  - The bit that completes lock is not itself counted in bit_cnt.
- locked_o falls on the edge sampling the LOSS_THR-th error in a window. That error is counted and pulses err_o.
- Sustained throughput is one bit per clock, and there are no stall outputs.

## Test plan
- **Clean lock:** generator feeds data_i from prbs_o, with data_val_i=ack_i=1 continuously after reset.
  - locked_o is 0 through the 40th bit and 1 from the cycle after the 41st bit.
  - After 1000 further bits: bit_cnt_o=1000, err_cnt_o=0, err_o never high.
- **Single error:** while locked, invert one bit.
  - Exactly one err_o pulse, one cycle after that bit.
  - err_cnt_o=1 and locked_o stays 1.
- **Loss of lock:** while locked, invert 8 bits within one 64-bit window.
  - locked_o falls after the 8th error and err_cnt_o=8.
  - With clean input afterwards, the checker relocks 41 bits later and err_cnt_o stays 8.
- **Gapped valid:** random data_val_i at about 30% duty, generator ack_i tied to data_val_i.
  - Lock occurs after 41 valid bits, not 41 cycles.
  - No errors, and bit_cnt_o equals the number of valid cycles while locked.
- **All-zero input:** data_i=0 with data_val_i=1 for 1000 cycles → locked_o stays 0 and err_cnt_o=0.
  - Then switch to the generator stream → the checker locks normally.
- **Clear and saturation** (CNT_W=4):
  - After 20 locked bits, bit_cnt_o=15.
  - clr_i pulsed on a valid cycle gives 0 on the next cycle, then counting resumes.
  - s_rst_i pulsed mid-lock returns all outputs to 0 on the next cycle.
